// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer.
//   seq_state_t  - sequencer state encoding (IDLE/RUN/WAIT/HALT), also
//                  exported on the state_o port.
//   loop_frame_t - one hardware-loop frame {start_addr, end_addr, remaining}.
//   ERR_*        - bit positions of the sticky error-cause vector.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } seq_state_t;

  // Frame fields are sized for the widest supported address/counter
  // (16 bits). The sequencer zero-extends into them and truncates back out,
  // so unused upper bits are constant and get optimised away.
  localparam int FRAME_FIELD_WIDTH = 16;

  typedef struct packed {
    logic [FRAME_FIELD_WIDTH-1:0] start_addr;
    logic [FRAME_FIELD_WIDTH-1:0] end_addr;
    logic [FRAME_FIELD_WIDTH-1:0] remaining;
  } loop_frame_t;

  localparam int ERR_CAUSES        = 3;
  localparam int ERR_CALL_OVERFLOW = 0;
  localparam int ERR_RET_UNDERFLOW = 1;
  localparam int ERR_LOOP_OVERFLOW = 2;

endpackage

// File: rtl/distributive_rom.sv
// distributive_rom: asynchronous-read ROM (LUT/distributed RAM style).
//   addr - read address
//   data - mem[addr], combinational
// The image is built at elaboration as all zeros; INIT_FILE names the
// intended image and is kept for interface compatibility.
module distributive_rom #(
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 12,
   parameter string INIT_FILE  = ""
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

   function automatic mem_t load_image();
      mem_t image;
      for (int i = 0; i < DEPTH; i++) image[i] = '0;
      return image;
   endfunction

   mem_t mem = load_image();

   // Combinational read of the current address
   assign data = mem[addr];

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: small register-based LIFO.
//   clk, rst   - clock, synchronous active-high reset (empties the stack)
//   clear      - synchronous empty request
//   push, pop  - push wr_data / discard top (ignored when full / empty)
//   set_top    - overwrite the top entry with wr_data (when not pushing)
//   wr_data    - data for push or set_top
//   top        - current top entry (undefined when empty)
//   full/empty - occupancy flags
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             set_top,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] entries [DEPTH];
  logic [CW-1:0]    count;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;

  // Index and flag decode from the occupancy count
  always_comb begin
    wr_idx  = IW'(count);
    top_idx = IW'(count - CW'(1));
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    top     = entries[top_idx];
  end

  // Occupancy count
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push && !full) begin
      entries[wr_idx] <= wr_data;
    end else if (set_top && !empty) begin
      entries[top_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: program counter with nested hardware loops, call/return
// stack, systolic-array stall and halt. Reads the instruction ROM
// combinationally at the current PC.
//   clk, rst        - clock, synchronous active-high reset
//   start           - leave IDLE/HALT and restart at PC 0
//   next_pc         - step strobe; controls below only act with it in RUN
//   load_pc         - jump to load_pc_addr
//   load_pc_addr    - jump/call target
//   call_en, ret_en - push return address and jump / pop return address
//   loop_en         - open a loop frame (loop_count, loop_end_addr)
//   wait_en         - step then stall until sa_done
//   sa_done         - systolic-array completion pulse (only seen in WAIT)
//   halt_en         - stop execution
//   pc, instr       - current PC and ROM[pc]
//   instr_valid     - high in RUN only
//   state_o         - state encoding (seq_state_t)
//   err             - sticky stack/loop overflow or underflow
// ADDR_WIDTH and CNT_WIDTH must not exceed FRAME_FIELD_WIDTH.
module instr_sequencer #(
  parameter int    INSTR_WIDTH = 32,
  parameter int    ADDR_WIDTH  = 12,
  parameter int    STACK_DEPTH = 4,
  parameter int    LOOP_DEPTH  = 2,
  parameter int    CNT_WIDTH   = 8,
  parameter string INIT_FILE   = "t1_instr.mem"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   next_pc,
  input  logic                   load_pc,
  input  logic [ADDR_WIDTH-1:0]  load_pc_addr,
  input  logic                   call_en,
  input  logic                   ret_en,
  input  logic                   loop_en,
  input  logic [CNT_WIDTH-1:0]   loop_count,
  input  logic [ADDR_WIDTH-1:0]  loop_end_addr,
  input  logic                   wait_en,
  input  logic                   sa_done,
  input  logic                   halt_en,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [1:0]             state_o,
  output logic                   err
);

  import seq_pkg::*;

  seq_state_t            state;
  seq_state_t            state_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ERR_CAUSES-1:0] err_cause;
  logic [ERR_CAUSES-1:0] err_set;

  logic                  stack_clear;
  logic                  call_push;
  logic                  call_pop;
  logic [ADDR_WIDTH-1:0] call_top;
  logic                  call_full;
  logic                  call_empty;

  logic                  loop_push;
  logic                  loop_pop;
  logic                  loop_set_top;
  loop_frame_t           loop_wr_data;
  loop_frame_t           loop_top;
  logic                  loop_full;
  logic                  loop_empty;
  logic                  loop_at_end;

  assign pc_inc      = pc + ADDR_WIDTH'(1);
  assign loop_at_end = !loop_empty && (pc == ADDR_WIDTH'(loop_top.end_addr));

  lifo_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clk     (clk),
    .rst     (rst),
    .clear   (stack_clear),
    .push    (call_push),
    .pop     (call_pop),
    .set_top (1'b0),
    .wr_data (pc_inc),
    .top     (call_top),
    .full    (call_full),
    .empty   (call_empty)
  );

  lifo_stack #(
    .WIDTH ($bits(loop_frame_t)),
    .DEPTH (LOOP_DEPTH)
  ) u_loop_stack (
    .clk     (clk),
    .rst     (rst),
    .clear   (stack_clear),
    .push    (loop_push),
    .pop     (loop_pop),
    .set_top (loop_set_top),
    .wr_data (loop_wr_data),
    .top     (loop_top),
    .full    (loop_full),
    .empty   (loop_empty)
  );

  distributive_rom #(
    .DATA_WIDTH (INSTR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_rom (
    .addr (pc),
    .data (instr)
  );

  // State, PC and sticky error register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      err_cause <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      err_cause <= err_cause | err_set;
    end
  end

  // Next state, next PC and stack commands. In RUN the PC actions are
  // mutually exclusive in priority order; wait_en only redirects the state.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    err_set      = '0;
    stack_clear  = 1'b0;
    call_push    = 1'b0;
    call_pop     = 1'b0;
    loop_push    = 1'b0;
    loop_pop     = 1'b0;
    loop_set_top = 1'b0;
    loop_wr_data.start_addr = FRAME_FIELD_WIDTH'(pc_inc);
    loop_wr_data.end_addr   = FRAME_FIELD_WIDTH'(loop_end_addr);
    loop_wr_data.remaining  = FRAME_FIELD_WIDTH'(loop_count);

    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt   = ST_RUN;
          pc_nxt      = '0;
          stack_clear = 1'b1;
        end
      end

      ST_RUN: begin
        if (next_pc) begin
          if (halt_en) begin
            state_nxt = ST_HALT;
          end else begin
            if (wait_en) state_nxt = ST_WAIT;
            pc_nxt = pc_inc;
            if (ret_en) begin
              if (call_empty) begin
                err_set[ERR_RET_UNDERFLOW] = 1'b1;
              end else begin
                call_pop = 1'b1;
                pc_nxt   = call_top;
              end
            end else if (call_en) begin
              if (call_full) err_set[ERR_CALL_OVERFLOW] = 1'b1;
              else           call_push = 1'b1;
              pc_nxt = load_pc_addr;
            end else if (load_pc) begin
              pc_nxt = load_pc_addr;
            end else if (loop_at_end) begin
              if (loop_top.remaining > FRAME_FIELD_WIDTH'(1)) begin
                pc_nxt                 = ADDR_WIDTH'(loop_top.start_addr);
                loop_set_top           = 1'b1;
                loop_wr_data           = loop_top;
                loop_wr_data.remaining = loop_top.remaining - FRAME_FIELD_WIDTH'(1);
              end else begin
                loop_pop = 1'b1;
              end
            end else if (loop_en) begin
              // A zero-count loop skips its body without needing a frame
              if (loop_count == '0)  pc_nxt = loop_end_addr + ADDR_WIDTH'(1);
              else if (loop_full)    err_set[ERR_LOOP_OVERFLOW] = 1'b1;
              else                   loop_push = 1'b1;
            end
          end
        end
      end

      ST_WAIT: begin
        if (sa_done) state_nxt = ST_RUN;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    instr_valid = (state == ST_RUN);
    state_o     = state;
    err         = |err_cause;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed vector table followed by randomized stimulus
// checked against a queue-based reference model of the sequencer.
module tb_instr_sequencer;

  localparam int AW = 12;
  localparam int unsigned AMASK = 32'h0000_0FFF;
  localparam int unsigned S_IDLE = 0;
  localparam int unsigned S_RUN  = 1;
  localparam int unsigned S_WAIT = 2;
  localparam int unsigned S_HALT = 3;
  localparam int CALL_DEPTH = 4;
  localparam int LOOPS      = 2;

  logic          clk = 1'b0;
  logic          rst, start, next_pc, load_pc, call_en, ret_en, loop_en;
  logic          wait_en, sa_done, halt_en;
  logic [AW-1:0] load_pc_addr, loop_end_addr;
  logic [7:0]    loop_count;
  logic [AW-1:0] pc;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [1:0]    state_o;
  logic          err;

  instr_sequencer #(
    .INSTR_WIDTH (32),
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (CALL_DEPTH),
    .LOOP_DEPTH  (LOOPS),
    .CNT_WIDTH   (8),
    .INIT_FILE   ("")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .next_pc       (next_pc),
    .load_pc       (load_pc),
    .load_pc_addr  (load_pc_addr),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .loop_en       (loop_en),
    .loop_count    (loop_count),
    .loop_end_addr (loop_end_addr),
    .wait_en       (wait_en),
    .sa_done       (sa_done),
    .halt_en       (halt_en),
    .pc            (pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .state_o       (state_o),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, start, next_pc, load, call, ret, loop, wait_en, sa_done, halt;
    int unsigned addr, lend, cnt;
  } ctrl_t;

  typedef enum {OP_NOP, OP_STEP, OP_START, OP_RST, OP_JMP, OP_CALL, OP_RET,
                OP_LOOP, OP_WAIT, OP_SAD, OP_HLW} op_t;

  typedef struct {
    op_t         op;
    int unsigned a, b, pc, st;
    bit          er;
  } vec_t;

  typedef struct {
    int unsigned s, e, r;
  } frame_t;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int unsigned m_pc = 0;
  int unsigned m_state = S_IDLE;
  bit          m_err = 1'b0;
  int unsigned call_q[$];
  frame_t      loop_q[$];

  vec_t tbl[$];

  function automatic ctrl_t mkCtrl(op_t op, int unsigned a, int unsigned b);
    ctrl_t c;
    c = '{default: 0};
    case (op)
      OP_STEP:  c.next_pc = 1;
      OP_START: c.start = 1;
      OP_RST:   c.rst = 1;
      OP_JMP:   begin c.next_pc = 1; c.load = 1; c.addr = a; end
      OP_CALL:  begin c.next_pc = 1; c.call = 1; c.addr = a; end
      OP_RET:   begin c.next_pc = 1; c.ret = 1; end
      OP_LOOP:  begin c.next_pc = 1; c.loop = 1; c.lend = a; c.cnt = b; end
      OP_WAIT:  begin c.next_pc = 1; c.wait_en = 1; end
      OP_SAD:   c.sa_done = 1;
      OP_HLW:   begin c.next_pc = 1; c.halt = 1; c.load = 1; c.wait_en = 1; c.addr = a; end
      default:  ;
    endcase
    return c;
  endfunction

  task automatic add(op_t op, int unsigned a, int unsigned b,
                     int unsigned epc, int unsigned est, bit eer);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.pc = epc; v.st = est; v.er = eer;
    tbl.push_back(v);
  endtask

  // One clock edge of the behavioural model
  task automatic modelStep(input ctrl_t c);
    int unsigned nxt;
    frame_t f;
    if (c.rst) begin
      m_pc = 0; m_state = S_IDLE; m_err = 0;
      call_q.delete(); loop_q.delete();
      return;
    end
    case (m_state)
      S_IDLE, S_HALT: begin
        if (c.start) begin
          m_state = S_RUN; m_pc = 0;
          call_q.delete(); loop_q.delete();
        end
      end
      S_WAIT: if (c.sa_done) m_state = S_RUN;
      default: begin
        if (c.next_pc) begin
          if (c.halt) begin
            m_state = S_HALT;
          end else begin
            nxt = (m_pc + 1) & AMASK;
            if (c.ret) begin
              if (call_q.size() > 0) nxt = call_q.pop_back();
              else m_err = 1;
            end else if (c.call) begin
              if (call_q.size() < CALL_DEPTH) call_q.push_back((m_pc + 1) & AMASK);
              else m_err = 1;
              nxt = c.addr & AMASK;
            end else if (c.load) begin
              nxt = c.addr & AMASK;
            end else if (loop_q.size() > 0 && loop_q[loop_q.size()-1].e == m_pc) begin
              f = loop_q[loop_q.size()-1];
              if (f.r > 1) begin
                f.r = f.r - 1;
                loop_q[loop_q.size()-1] = f;
                nxt = f.s;
              end else begin
                void'(loop_q.pop_back());
              end
            end else if (c.loop) begin
              if (c.cnt == 0) nxt = (c.lend + 1) & AMASK;
              else if (loop_q.size() < LOOPS) begin
                f.s = nxt; f.e = c.lend & AMASK; f.r = c.cnt;
                loop_q.push_back(f);
              end else m_err = 1;
            end
            if (c.wait_en) m_state = S_WAIT;
            m_pc = nxt;
          end
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle at negedge
  task automatic applyStimulus(input ctrl_t c);
    rst = c.rst; start = c.start; next_pc = c.next_pc; load_pc = c.load;
    call_en = c.call; ret_en = c.ret; loop_en = c.loop; wait_en = c.wait_en;
    sa_done = c.sa_done; halt_en = c.halt;
    load_pc_addr = AW'(c.addr); loop_end_addr = AW'(c.lend); loop_count = 8'(c.cnt);
    @(posedge clk);
    modelStep(c);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int unsigned exp_pc,
                             input int unsigned exp_st, input bit exp_err);
    logic [AW-1:0] want_pc;
    logic [1:0]    want_st;
    want_pc = AW'(exp_pc);
    want_st = 2'(exp_st);
    checks++;
    if (pc !== want_pc) begin
      errors++;
      $display("[TB] FAIL %s pc: got 0x%0h want 0x%0h", name, pc, want_pc);
    end
    checks++;
    if (state_o !== want_st) begin
      errors++;
      $display("[TB] FAIL %s state: got %0d want %0d", name, state_o, want_st);
    end
    checks++;
    if (instr_valid !== (exp_st == S_RUN)) begin
      errors++;
      $display("[TB] FAIL %s instr_valid: got %b want %b", name, instr_valid, exp_st == S_RUN);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("[TB] FAIL %s err: got %b want %b", name, err, exp_err);
    end
  endtask

  initial begin
    ctrl_t c;

    // Reset, then single loop at pc=2: 3,4,3,4,3,4,5
    add(OP_RST,   0,     0, 0,     S_IDLE, 0);
    add(OP_START, 0,     0, 0,     S_RUN,  0);
    add(OP_STEP,  0,     0, 1,     S_RUN,  0);
    add(OP_STEP,  0,     0, 2,     S_RUN,  0);
    add(OP_LOOP,  4,     3, 3,     S_RUN,  0);
    add(OP_STEP,  0,     0, 4,     S_RUN,  0);
    add(OP_STEP,  0,     0, 3,     S_RUN,  0);
    add(OP_STEP,  0,     0, 4,     S_RUN,  0);
    add(OP_STEP,  0,     0, 3,     S_RUN,  0);
    add(OP_STEP,  0,     0, 4,     S_RUN,  0);
    add(OP_STEP,  0,     0, 5,     S_RUN,  0);
    add(OP_STEP,  0,     0, 6,     S_RUN,  0);
    // Nested: outer body 1..6 x2, inner body 3..4 x2, third loop overflows
    add(OP_JMP,   0,     0, 0,     S_RUN,  0);
    add(OP_LOOP,  6,     2, 1,     S_RUN,  0);
    add(OP_STEP,  0,     0, 2,     S_RUN,  0);
    add(OP_LOOP,  4,     2, 3,     S_RUN,  0);
    add(OP_STEP,  0,     0, 4,     S_RUN,  0);
    add(OP_STEP,  0,     0, 3,     S_RUN,  0);
    add(OP_STEP,  0,     0, 4,     S_RUN,  0);
    add(OP_STEP,  0,     0, 5,     S_RUN,  0);
    add(OP_STEP,  0,     0, 6,     S_RUN,  0);
    add(OP_STEP,  0,     0, 1,     S_RUN,  0);
    add(OP_STEP,  0,     0, 2,     S_RUN,  0);
    add(OP_LOOP,  4,     2, 3,     S_RUN,  0);
    add(OP_LOOP,  9,     5, 4,     S_RUN,  1);
    add(OP_STEP,  0,     0, 3,     S_RUN,  1);
    add(OP_STEP,  0,     0, 4,     S_RUN,  1);
    add(OP_STEP,  0,     0, 5,     S_RUN,  1);
    add(OP_STEP,  0,     0, 6,     S_RUN,  1);
    add(OP_STEP,  0,     0, 7,     S_RUN,  1);
    // Reset mid-RUN at pc=5 with a loop frame open
    add(OP_RST,   0,     0, 0,     S_IDLE, 0);
    add(OP_START, 0,     0, 0,     S_RUN,  0);
    add(OP_JMP,   3,     0, 3,     S_RUN,  0);
    add(OP_LOOP,  6,     3, 4,     S_RUN,  0);
    add(OP_STEP,  0,     0, 5,     S_RUN,  0);
    add(OP_RST,   0,     0, 0,     S_IDLE, 0);
    add(OP_START, 0,     0, 0,     S_RUN,  0);
    add(OP_JMP,   5,     0, 5,     S_RUN,  0);
    add(OP_STEP,  0,     0, 6,     S_RUN,  0);
    add(OP_STEP,  0,     0, 7,     S_RUN,  0);
    // Call/return, then return on empty stack
    add(OP_JMP,   'h10,  0, 'h10,  S_RUN,  0);
    add(OP_CALL,  'h40,  0, 'h40,  S_RUN,  0);
    add(OP_STEP,  0,     0, 'h41,  S_RUN,  0);
    add(OP_STEP,  0,     0, 'h42,  S_RUN,  0);
    add(OP_RET,   0,     0, 'h11,  S_RUN,  0);
    add(OP_RET,   0,     0, 'h12,  S_RUN,  1);
    // Wait at pc=8, load_pc ignored in WAIT, sa_done 5 edges later
    add(OP_RST,   0,     0, 0,     S_IDLE, 0);
    add(OP_START, 0,     0, 0,     S_RUN,  0);
    add(OP_JMP,   8,     0, 8,     S_RUN,  0);
    add(OP_WAIT,  0,     0, 9,     S_WAIT, 0);
    add(OP_JMP,   'h30,  0, 9,     S_WAIT, 0);
    add(OP_NOP,   0,     0, 9,     S_WAIT, 0);
    add(OP_NOP,   0,     0, 9,     S_WAIT, 0);
    add(OP_NOP,   0,     0, 9,     S_WAIT, 0);
    add(OP_SAD,   0,     0, 9,     S_RUN,  0);
    add(OP_STEP,  0,     0, 'hA,   S_RUN,  0);
    // sa_done in RUN is dropped, not remembered
    add(OP_SAD,   0,     0, 'hA,   S_RUN,  0);
    add(OP_WAIT,  0,     0, 'hB,   S_WAIT, 0);
    add(OP_NOP,   0,     0, 'hB,   S_WAIT, 0);
    add(OP_SAD,   0,     0, 'hB,   S_RUN,  0);
    // halt+load+wait together, restart, wrap, zero-count loop, start in RUN
    add(OP_JMP,   'h20,  0, 'h20,  S_RUN,  0);
    add(OP_HLW,   'h50,  0, 'h20,  S_HALT, 0);
    add(OP_STEP,  0,     0, 'h20,  S_HALT, 0);
    add(OP_START, 0,     0, 0,     S_RUN,  0);
    add(OP_RET,   0,     0, 1,     S_RUN,  1);
    add(OP_JMP,   'hFFF, 0, 'hFFF, S_RUN,  1);
    add(OP_STEP,  0,     0, 0,     S_RUN,  1);
    add(OP_LOOP,  'hFFF, 0, 0,     S_RUN,  1);
    add(OP_STEP,  0,     0, 1,     S_RUN,  1);
    add(OP_START, 0,     0, 1,     S_RUN,  1);

    $display("[TB] directed table: %0d rows", tbl.size());
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(mkCtrl(tbl[i].op, tbl[i].a, tbl[i].b));
      checkOutput($sformatf("row%0d", i), tbl[i].pc, tbl[i].st, tbl[i].er);
    end

    $display("[TB] randomized phase");
    for (int i = 0; i < 600; i++) begin
      c = '{default: 0};
      c.rst     = ($urandom_range(0, 99) < 2);
      c.start   = ($urandom_range(0, 99) < 10);
      c.next_pc = ($urandom_range(0, 99) < 80);
      c.halt    = ($urandom_range(0, 99) < 3);
      c.ret     = ($urandom_range(0, 99) < 12);
      c.call    = ($urandom_range(0, 99) < 12);
      c.load    = ($urandom_range(0, 99) < 10);
      c.loop    = ($urandom_range(0, 99) < 20);
      c.wait_en = ($urandom_range(0, 99) < 8);
      c.sa_done = ($urandom_range(0, 99) < 30);
      c.addr    = $urandom_range(0, 40);
      c.lend    = (m_pc + $urandom_range(0, 5)) & AMASK;
      c.cnt     = $urandom_range(0, 3);
      applyStimulus(c);
      checkOutput($sformatf("rand%0d", i), m_pc, m_state, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
